id_ex: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS-32 pipeline.
- Captures decoded control bits, register-file read data, the sign-extended immediate and register specifiers from the ID stage on each rising clock edge.
- Presents them to the EX stage: ALU, RegDst mux and forwarding unit.
- Supports an asynchronous reset and a synchronous flush (bubble insertion).

---
 rtl/id_ex_if.sv | 79 +++++++
 rtl/id_ex.sv | 114 +++++++++++
 tb/tb_id_ex.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// ----------------------------------------------------------------------------
// id_ex_if : signal bundle between the ID stage, the ID/EX pipeline register
//            and the EX stage of the 5-stage MIPS-32 pipeline.
//
// Parameters:
//   DATA_W  width of register-file data and the sign-extended immediate
//   REG_W   width of the register specifiers
//
// Signals:
//   *_in   driven by the ID stage (decoded control, read data, immediate,
//          rs/rt/rd specifiers)
//   *_out  driven by the pipeline register, consumed by ALU, RegDst mux and
//          the forwarding unit
//
// Modports:
//   master  ID/EX environment side: drives *_in, observes *_out
//   slave   pipeline register side: samples *_in, drives *_out
// ----------------------------------------------------------------------------
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);

  // ID-stage side
  logic              RegWrite_in;
  logic              MemtoReg_in;
  logic              MemRead_in;
  logic              MemWrite_in;
  logic              RegDst_in;
  logic              ALU_Op_in;
  logic              ALU_Src_in;
  logic [DATA_W-1:0] Read_Data_1_in;
  logic [DATA_W-1:0] Read_Data_2_in;
  logic [DATA_W-1:0] sign_extend_in;
  logic [REG_W-1:0]  IF_ID_Rs_in;
  logic [REG_W-1:0]  IF_ID_Rt_in;
  logic [REG_W-1:0]  ID_Rd_in;

  // EX-stage side
  logic              RegWrite_out;
  logic              MemtoReg_out;
  logic              MemRead_out;
  logic              MemWrite_out;
  logic              RegDst_out;
  logic              ALU_Op_out;
  logic              ALU_Src_out;
  logic [DATA_W-1:0] Read_Data_1_out;
  logic [DATA_W-1:0] Read_Data_2_out;
  logic [DATA_W-1:0] sign_extend_out;
  logic [REG_W-1:0]  ID_EX_Rs_Forward_out;
  logic [REG_W-1:0]  ID_EX_Rt_Forward_out;
  logic [REG_W-1:0]  ID_EX_Rt_MUX_out;
  logic [REG_W-1:0]  ID_EX_Rs_MUX_out;

  modport master (
    output RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
           RegDst_in, ALU_Op_in, ALU_Src_in,
           Read_Data_1_in, Read_Data_2_in, sign_extend_in,
           IF_ID_Rs_in, IF_ID_Rt_in, ID_Rd_in,
    input  RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
           RegDst_out, ALU_Op_out, ALU_Src_out,
           Read_Data_1_out, Read_Data_2_out, sign_extend_out,
           ID_EX_Rs_Forward_out, ID_EX_Rt_Forward_out,
           ID_EX_Rt_MUX_out, ID_EX_Rs_MUX_out
  );

  modport slave (
    input  RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
           RegDst_in, ALU_Op_in, ALU_Src_in,
           Read_Data_1_in, Read_Data_2_in, sign_extend_in,
           IF_ID_Rs_in, IF_ID_Rt_in, ID_Rd_in,
    output RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out,
           RegDst_out, ALU_Op_out, ALU_Src_out,
           Read_Data_1_out, Read_Data_2_out, sign_extend_out,
           ID_EX_Rs_Forward_out, ID_EX_Rt_Forward_out,
           ID_EX_Rt_MUX_out, ID_EX_Rs_MUX_out
  );

endinterface

// File: rtl/id_ex.sv
// ----------------------------------------------------------------------------
// id_ex : ID/EX pipeline register of the 5-stage MIPS-32 pipeline.
//
// Captures the decoded control bits, register-file read data, sign-extended
// immediate and rs/rt/rd specifiers on every rising clock edge and presents
// them to the EX stage one cycle later. Every output is a flop; there is no
// combinational path from any input to any output.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every output, data included
//   flush  synchronous bubble insert; control outputs clear at the next edge
//          while data/specifiers still load
//   stall  hold every output (present only when ID_EX_STALL_EN is defined)
//   bus    id_ex_if.slave bundle carrying all *_in / *_out signals
//
// Build option:
//   ID_EX_STALL_EN  defined   -> stall port exists and holds the register
//                   undefined -> register loads on every non-reset edge
//
// Priority at an edge: rst_n > flush > stall > load.
// ----------------------------------------------------------------------------
module id_ex #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
`ifdef ID_EX_STALL_EN
  input  logic    stall,
`endif
  id_ex_if.slave  bus
);

  // Control bits kept together so a bubble is a single '0 assignment.
  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic mem_read;
    logic mem_write;
    logic reg_dst;
    logic alu_op;
    logic alu_src;
  } ctrl_t;

  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;
  logic              load_en;

  assign ctrl_d = '{
    reg_write: bus.RegWrite_in,
    memto_reg: bus.MemtoReg_in,
    mem_read:  bus.MemRead_in,
    mem_write: bus.MemWrite_in,
    reg_dst:   bus.RegDst_in,
    alu_op:    bus.ALU_Op_in,
    alu_src:   bus.ALU_Src_in
  };

`ifdef ID_EX_STALL_EN
  assign load_en = ~stall;
`else
  assign load_en = 1'b1;
`endif

  // A flush overrides a stall: the bubble must still enter the pipe, and the
  // data fields load alongside it because EX ignores them for a NOP.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else if (flush || load_en) begin
      ctrl_q <= flush ? ctrl_t'('0) : ctrl_d;
      rd1_q  <= bus.Read_Data_1_in;
      rd2_q  <= bus.Read_Data_2_in;
      imm_q  <= bus.sign_extend_in;
      rs_q   <= bus.IF_ID_Rs_in;
      rt_q   <= bus.IF_ID_Rt_in;
      rd_q   <= bus.ID_Rd_in;
    end
  end

  assign bus.RegWrite_out         = ctrl_q.reg_write;
  assign bus.MemtoReg_out         = ctrl_q.memto_reg;
  assign bus.MemRead_out          = ctrl_q.mem_read;
  assign bus.MemWrite_out         = ctrl_q.mem_write;
  assign bus.RegDst_out           = ctrl_q.reg_dst;
  assign bus.ALU_Op_out           = ctrl_q.alu_op;
  assign bus.ALU_Src_out          = ctrl_q.alu_src;
  assign bus.Read_Data_1_out      = rd1_q;
  assign bus.Read_Data_2_out      = rd2_q;
  assign bus.sign_extend_out      = imm_q;
  assign bus.ID_EX_Rs_Forward_out = rs_q;
  // rt feeds both the forwarding unit and RegDst mux input 0 from one flop.
  assign bus.ID_EX_Rt_Forward_out = rt_q;
  assign bus.ID_EX_Rt_MUX_out     = rt_q;
  // The "Rs_MUX" name is historical: this is rd, RegDst mux input 1.
  assign bus.ID_EX_Rs_MUX_out     = rd_q;

endmodule

// File: tb/tb_id_ex.sv
// ----------------------------------------------------------------------------
// tb_id_ex : self-checking bench for the ID/EX pipeline register.
// Directed steps followed by randomized traffic, compared against a
// behavioural model: after each edge the register shows the input snapshot
// taken before that edge (control zeroed on flush, previous value on stall).
// ----------------------------------------------------------------------------
module tb_id_ex;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // One ID-stage input set. ctrl order: RegWrite, MemtoReg, MemRead,
  // MemWrite, RegDst, ALU_Op, ALU_Src.
  typedef struct packed {
    logic [6:0]        ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
  } vec_t;

  // Everything visible at the EX side.
  typedef struct packed {
    logic [6:0]        ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs_fwd;
    logic [REG_W-1:0]  rt_fwd;
    logic [REG_W-1:0]  rt_mux;
    logic [REG_W-1:0]  rd_mux;
  } out_t;

  logic clk;
  logic rst_n;
  logic flush;
`ifdef ID_EX_STALL_EN
  logic stall;
`endif

  int checks = 0;
  int errors = 0;

  vec_t cur;
  out_t exp_q;

  id_ex_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  id_ex #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
`ifdef ID_EX_STALL_EN
    .stall (stall),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t rand_vec();
    vec_t v;
    v.ctrl = 7'($urandom_range(0, 127));
    v.rd1  = $urandom;
    v.rd2  = $urandom;
    v.imm  = $urandom;
    v.rs   = 5'($urandom_range(0, 31));
    v.rt   = 5'($urandom_range(0, 31));
    v.rd   = 5'($urandom_range(0, 31));
    return v;
  endfunction

  // What EX should see after an edge that captured v.
  function automatic out_t expect_of(vec_t v, bit bubble);
    out_t o;
    o.ctrl   = bubble ? 7'd0 : v.ctrl;
    o.rd1    = v.rd1;
    o.rd2    = v.rd2;
    o.imm    = v.imm;
    o.rs_fwd = v.rs;
    o.rt_fwd = v.rt;
    o.rt_mux = v.rt;
    o.rd_mux = v.rd;
    return o;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.ctrl   = {bus.RegWrite_out, bus.MemtoReg_out, bus.MemRead_out,
                bus.MemWrite_out, bus.RegDst_out, bus.ALU_Op_out,
                bus.ALU_Src_out};
    o.rd1    = bus.Read_Data_1_out;
    o.rd2    = bus.Read_Data_2_out;
    o.imm    = bus.sign_extend_out;
    o.rs_fwd = bus.ID_EX_Rs_Forward_out;
    o.rt_fwd = bus.ID_EX_Rt_Forward_out;
    o.rt_mux = bus.ID_EX_Rt_MUX_out;
    o.rd_mux = bus.ID_EX_Rs_MUX_out;
    return o;
  endfunction

  task automatic drive(input vec_t v);
    cur = v;
    {bus.RegWrite_in, bus.MemtoReg_in, bus.MemRead_in, bus.MemWrite_in,
     bus.RegDst_in, bus.ALU_Op_in, bus.ALU_Src_in} = v.ctrl;
    bus.Read_Data_1_in = v.rd1;
    bus.Read_Data_2_in = v.rd2;
    bus.sign_extend_in = v.imm;
    bus.IF_ID_Rs_in    = v.rs;
    bus.IF_ID_Rt_in    = v.rt;
    bus.ID_Rd_in       = v.rd;
  endtask

  task automatic check(input string tag, input out_t obs, input out_t want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Advance one rising edge, updating the model from the pre-edge inputs.
  task automatic tick();
    out_t nxt;
    if (!rst_n)       nxt = '0;
    else if (flush)   nxt = expect_of(cur, 1'b1);
`ifdef ID_EX_STALL_EN
    else if (stall)   nxt = exp_q;
`endif
    else              nxt = expect_of(cur, 1'b0);
    @(posedge clk);
    #1;
    exp_q = nxt;
  endtask

  initial begin
    vec_t v;
    vec_t va;
    vec_t vb;

    // Reset with nonzero inputs: outputs zero immediately and across edges.
    rst_n = 1'b0;
    flush = 1'b0;
`ifdef ID_EX_STALL_EN
    stall = 1'b0;
`endif
    v = rand_vec();
    v.ctrl = 7'h7f;
    drive(v);
    exp_q = '0;
    #1;
    check("reset_async", observe(), '0);
    tick();
    check("reset_hold", observe(), '0);

    // Release mid-cycle; nothing loads before the next edge.
    #2 rst_n = 1'b1;
    v = '0;
    v.rd1 = 32'h0000000A;
    v.rd2 = 32'hDEADBEEF;
    v.imm = 32'hFFFFFFFC;
    drive(v);
    #1;
    check("data_pre_edge", observe(), '0);
    tick();
    check("data_pass", observe(), expect_of(v, 1'b0));

    // Specifiers and control bits.
    v = '0;
    v.ctrl = 7'h7f;
    v.rs = 5'd3;
    v.rt = 5'd7;
    v.rd = 5'd12;
    drive(v);
    tick();
    check("spec_ctrl", observe(), expect_of(v, 1'b0));

    // Flush: bubble with data still loaded.
    v = '0;
    v.ctrl = 7'h7f;
    v.rd1 = 32'h55;
    drive(v);
    flush = 1'b1;
    tick();
    check("flush", observe(), expect_of(v, 1'b1));
    flush = 1'b0;

    // Back-to-back: each edge shows the set applied just before it.
    for (int i = 0; i < 3; i++) begin
      drive(rand_vec());
      #2;
      check("b2b_pre_edge", observe(), exp_q);
      tick();
      check("b2b", observe(), exp_q);
    end

    // Reset mid-cycle clears at once; first edge after release loads.
    #2 rst_n = 1'b0;
    #1;
    exp_q = '0;
    check("reset_mid", observe(), '0);
    #2 rst_n = 1'b1;
    v = rand_vec();
    drive(v);
    tick();
    check("post_reset_load", observe(), expect_of(v, 1'b0));

`ifdef ID_EX_STALL_EN
    // Stall holds A while B waits, then B loads.
    va = rand_vec();
    vb = rand_vec();
    drive(va);
    tick();
    check("stall_load_a", observe(), expect_of(va, 1'b0));
    drive(vb);
    stall = 1'b1;
    tick();
    check("stall_hold", observe(), expect_of(va, 1'b0));
    tick();
    check("stall_hold2", observe(), expect_of(va, 1'b0));
    stall = 1'b0;
    tick();
    check("stall_release", observe(), expect_of(vb, 1'b0));
    // Stall together with flush: flush wins.
    v = rand_vec();
    v.ctrl = 7'h7f;
    drive(v);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("stall_flush", observe(), expect_of(v, 1'b1));
    stall = 1'b0;
    flush = 1'b0;
`else
    va = rand_vec();
    vb = rand_vec();
    drive(va);
    tick();
    check("load_a", observe(), expect_of(va, 1'b0));
    drive(vb);
    tick();
    check("load_b", observe(), expect_of(vb, 1'b0));
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      drive(rand_vec());
      flush = ($urandom_range(0, 3) == 0);
`ifdef ID_EX_STALL_EN
      stall = ($urandom_range(0, 3) == 0);
`endif
      #2;
      check("rand_pre_edge", observe(), exp_q);
      tick();
      check("rand", observe(), exp_q);
    end
    flush = 1'b0;
`ifdef ID_EX_STALL_EN
    stall = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
